// File: rtl/rob_sn_scheduler.sv
// rob_sn_scheduler: front-end controller for the ROB op-centric queue.
//
// Hands out sequence numbers in program order, bounding outstanding SNs to
// p_depth; round-robin arbitrates p_nreq completion sources onto the queue's
// single insert port; republishes each retirement as a registered pulse.
//
// Ports:
//   clk, rst                  clock, async active-low reset
//   alloc_req/gnt/sn          SN allocation handshake (combinational grant)
//   cpl_val/sn/data, cpl_rdy  packed per-requester completions, one-hot accept
//   ins_en/sn_in/data_in      insert port towards the queue
//   ins_cpl                   queue accepted the insert this cycle
//   deq_front_cpl/data        head retirement from the queue
//   ret_val, ret_data         registered retire pulse and payload
//   outstanding               allocated-but-not-retired count
//
// Arbiter states:
//   state  | meaning
//   S_IDLE | no insert in flight; pick a winner from rr_ptr upward each cycle
//   S_HOLD | winner presented but not yet accepted; keep driving it

`ifndef ROB_DEPTH
`define ROB_DEPTH 8
`endif
`ifndef ROB_BITWIDTH
`define ROB_BITWIDTH 8
`endif

module rob_sn_scheduler #(
    parameter int p_depth    = `ROB_DEPTH,
    parameter int p_ptrwidth = $clog2(p_depth),
    parameter int p_bitwidth = `ROB_BITWIDTH,
    parameter int p_nreq     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alloc_req,
    output logic                           alloc_gnt,
    output logic [p_ptrwidth-1:0]          alloc_sn,
    input  logic [p_nreq-1:0]              cpl_val,
    input  logic [p_nreq*p_ptrwidth-1:0]   cpl_sn,
    input  logic [p_nreq*p_bitwidth-1:0]   cpl_data,
    output logic [p_nreq-1:0]              cpl_rdy,
    output logic                           ins_en,
    output logic [p_ptrwidth-1:0]          ins_sn_in,
    output logic [p_bitwidth-1:0]          ins_data_in,
    input  logic                           ins_cpl,
    input  logic                           deq_front_cpl,
    input  logic [p_bitwidth-1:0]          deq_front_data,
    output logic                           ret_val,
    output logic [p_bitwidth-1:0]          ret_data,
    output logic [p_ptrwidth:0]            outstanding
);

    localparam int idx_w = $clog2(p_nreq);
    localparam logic [p_ptrwidth:0]   depth_c    = (p_ptrwidth+1)'(p_depth);
    localparam logic [p_ptrwidth-1:0] last_sn_c  = (p_ptrwidth)'(p_depth-1);
    localparam logic [idx_w:0]        nreq_c     = (idx_w+1)'(p_nreq);
    localparam logic [idx_w-1:0]      last_idx_c = (idx_w)'(p_nreq-1);

    typedef enum logic {S_IDLE, S_HOLD} arb_state_t;

    arb_state_t             state;
    logic [idx_w-1:0]       rr_ptr;
    logic [idx_w-1:0]       winner;
    logic [idx_w-1:0]       pick;
    logic [idx_w-1:0]       sel;
    logic [idx_w-1:0]       next_rr;
    logic [idx_w:0]         cand;
    logic                   any_val;
    logic [p_ptrwidth-1:0]  alloc_ptr;

    logic [p_ptrwidth-1:0]  sn_arr   [p_nreq];
    logic [p_bitwidth-1:0]  data_arr [p_nreq];

    for (genvar g = 0; g < p_nreq; g++) begin : g_unpack
        assign sn_arr[g]   = cpl_sn[g*p_ptrwidth +: p_ptrwidth];
        assign data_arr[g] = cpl_data[g*p_bitwidth +: p_bitwidth];
    end

    // ---------------- SN allocation and occupancy ----------------
    // No retire bypass: a full buffer refuses even if the head retires now.
    assign alloc_gnt = alloc_req && (outstanding < depth_c);
    assign alloc_sn  = alloc_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ptr   <= '0;
            outstanding <= '0;
        end else begin
            if (alloc_gnt)
                alloc_ptr <= (alloc_ptr == last_sn_c) ? '0 : alloc_ptr + 1'b1;
            case ({alloc_gnt, deq_front_cpl})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
                default: ;
            endcase
        end
    end

    // Retiring from an empty buffer means the queue and this block disagree.
    assert property (@(posedge clk) disable iff (!rst)
                     !(deq_front_cpl && outstanding == '0));

    // ---------------- completion arbiter ----------------
    // First valid requester at or after rr_ptr, wrapping modulo p_nreq.
    always_comb begin
        pick    = rr_ptr;
        any_val = 1'b0;
        cand    = '0;
        for (int i = 0; i < p_nreq; i++) begin
            cand = {1'b0, rr_ptr} + (idx_w+1)'(i);
            if (cand >= nreq_c)
                cand = cand - nreq_c;
            if (!any_val && cpl_val[cand[idx_w-1:0]]) begin
                any_val = 1'b1;
                pick    = cand[idx_w-1:0];
            end
        end
    end

    assign sel     = (state == S_HOLD) ? winner : pick;
    assign next_rr = (sel == last_idx_c) ? '0 : sel + 1'b1;

    // Gated by rst so an in-flight grant is dropped the moment reset asserts,
    // even while requesters are still presenting.
    assign ins_en      = rst && ((state == S_HOLD) || any_val);
    assign ins_sn_in   = sn_arr[sel];
    assign ins_data_in = data_arr[sel];
    assign cpl_rdy     = (ins_en && ins_cpl) ? ((p_nreq)'(1) << sel) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            winner <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_val) begin
                        winner <= pick;
                        if (ins_cpl)
                            rr_ptr <= next_rr;
                        else
                            state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ins_cpl) begin
                        rr_ptr <= next_rr;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------- retire republish ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_val  <= 1'b0;
            ret_data <= '0;
        end else begin
            ret_val <= deq_front_cpl;
            if (deq_front_cpl)
                ret_data <= deq_front_data;
        end
    end

endmodule
